ram_seq: RTL and testbench

RAM_SEQ -- requirements
Module: ram_seq

---
 rtl/ram_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_ram_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_seq.sv
// ---------------------------------------------------------------------------
// ram_seq -- single-port word memory with a small command sequencer.
//
// Commands (CMD_OP): 00 read, 01 write, 10 fill, 11 clear. A command is
// accepted on a rising CLK edge where CMD_VALID and CMD_READY are both high.
// Read and write complete in IDLE, so one can be accepted every cycle.
// Fill and clear write one word per cycle. The first word is written at the
// accept edge. The remaining words are written from latched state.
//
// Optional feature macro: RAM_SEQ_PARITY_EN. When it is defined, each word
// stores an even-parity bit, and a mismatch on a read raises RD_PERR
// together with RD_VALID. When it is undefined, RD_PERR is always 0.
//
// Parameters
//   DATA_W     data word width (default 4)
//   ADDR_W     address width; DEPTH = 2**ADDR_W words (default 5)
// Ports
//   CLK        clock, rising edge
//   RST        synchronous active-high reset (memory contents untouched)
//   CMD_VALID  command request
//   CMD_READY  command accepted this cycle (IDLE and not in reset)
//   CMD_OP     operation code
//   CMD_ADDR   start address
//   CMD_DATA   write / fill data
//   CMD_LEN    fill word count minus one
//   RD_VALID   one-cycle strobe, RD_DATA valid
//   RD_DATA    read data, holds its value between reads
//   BUSY       fill or clear in progress
//   DONE       one-cycle pulse after the last word of a fill or clear
//   RD_PERR    parity error on the current read
// ---------------------------------------------------------------------------
module ram_seq #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [1:0]        CMD_OP,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_DATA,
    input  logic [ADDR_W-1:0] CMD_LEN,
    output logic              RD_VALID,
    output logic [DATA_W-1:0] RD_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              RD_PERR
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_SEQ_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    localparam logic [1:0]        OP_READ  = 2'b00;
    localparam logic [1:0]        OP_WRITE = 2'b01;
    localparam logic [1:0]        OP_FILL  = 2'b10;
    localparam logic [1:0]        OP_CLEAR = 2'b11;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // Build the stored word: data, plus the parity bit when that is enabled.
    function automatic logic [WORD_W-1:0] encode_word(input logic [DATA_W-1:0] d);
`ifdef RAM_SEQ_PARITY_EN
        return {even_parity(d), d};
`else
        return d;
`endif
    endfunction

    logic [WORD_W-1:0] mem [DEPTH];

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;      // next address of a fill or clear
    logic [ADDR_W-1:0]   cnt_q, cnt_d;        // words still to write after this one
    logic [DATA_W-1:0]   data_q, data_d;      // latched fill data (zero for clear)
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_perr_q, rd_perr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                accept;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [WORD_W-1:0]   rd_word;

    assign CMD_READY = (state_q == ST_IDLE) && !RST;
    assign accept    = CMD_VALID && CMD_READY;
    assign rd_word   = mem[CMD_ADDR];

    assign RD_VALID  = rd_valid_q;
    assign RD_DATA   = rd_data_q;
    assign RD_PERR   = rd_perr_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

    // Next-state, memory write port and read-output computation.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_perr_d  = 1'b0;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = CMD_ADDR;
        wr_data    = CMD_DATA;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (CMD_OP)
                        OP_READ: begin
                            rd_valid_d = 1'b1;
                            rd_data_d  = rd_word[DATA_W-1:0];
`ifdef RAM_SEQ_PARITY_EN
                            rd_perr_d  = ^rd_word;
`else
                            rd_perr_d  = 1'b0;
`endif
                        end
                        OP_WRITE: begin
                            wr_en = 1'b1;
                        end
                        OP_FILL: begin
                            // The first word is written now. The rest come
                            // from the latched copy, so the inputs may change.
                            wr_en  = 1'b1;
                            addr_d = CMD_ADDR + ADDR_ONE;
                            data_d = CMD_DATA;
                            cnt_d  = CMD_LEN;
                            if (CMD_LEN == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = ST_FILL;
                            end
                        end
                        OP_CLEAR: begin
                            wr_en   = 1'b1;
                            wr_addr = '0;
                            wr_data = '0;
                            addr_d  = ADDR_ONE;
                            data_d  = '0;
                            cnt_d   = '1;
                            state_d = ST_CLEAR;
                        end
                        default: begin
                            wr_en = 1'b0;
                        end
                    endcase
                end else begin
                    wr_en = 1'b0;
                end
            end
            ST_FILL, ST_CLEAR: begin
                // A reset edge aborts the sequence without writing.
                wr_en   = !RST;
                wr_addr = addr_q;
                wr_data = data_q;
                addr_d  = addr_q + ADDR_ONE;   // wraps modulo DEPTH
                cnt_d   = cnt_q - ADDR_ONE;
                if (cnt_q == ADDR_ONE) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Sequencer state and registered outputs, with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_perr_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_perr_q  <= rd_perr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Memory array write port. It has no reset, so contents survive RST.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_addr] <= encode_word(wr_data);
        end
    end

endmodule

// File: tb/tb_ram_seq.sv
// ---------------------------------------------------------------------------
// tb_ram_seq -- self-checking bench for ram_seq.
// Instance A uses the default parameters (DATA_W=4, ADDR_W=5).
// Instance B uses DATA_W=8, ADDR_W=4 for the write-then-read sequence.
// The reference is a plain word array, updated at the level of whole
// commands. Fill and clear latency is derived from the word count.
// ---------------------------------------------------------------------------
module tb_ram_seq;

    logic       CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Instance A (defaults)
    logic       RST, CMD_VALID, CMD_READY, RD_VALID, BUSY, DONE, RD_PERR;
    logic [1:0] CMD_OP;
    logic [4:0] CMD_ADDR, CMD_LEN;
    logic [3:0] CMD_DATA, RD_DATA;

    // Instance B (DATA_W=8, ADDR_W=4)
    logic       b_rst, b_cmd_valid, b_cmd_ready, b_rd_valid, b_busy, b_done, b_rd_perr;
    logic [1:0] b_cmd_op;
    logic [3:0] b_cmd_addr, b_cmd_len;
    logic [7:0] b_cmd_data, b_rd_data;

    ram_seq dut_a (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_LEN(CMD_LEN),
        .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .BUSY(BUSY), .DONE(DONE), .RD_PERR(RD_PERR)
    );

    ram_seq #(.DATA_W(8), .ADDR_W(4)) dut_b (
        .CLK(CLK), .RST(b_rst), .CMD_VALID(b_cmd_valid), .CMD_READY(b_cmd_ready),
        .CMD_OP(b_cmd_op), .CMD_ADDR(b_cmd_addr), .CMD_DATA(b_cmd_data), .CMD_LEN(b_cmd_len),
        .RD_VALID(b_rd_valid), .RD_DATA(b_rd_data), .BUSY(b_busy), .DONE(b_done), .RD_PERR(b_rd_perr)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] ref_mem [32];
    logic [3:0] last_rd;

    typedef struct {
        logic [1:0] op;
        logic [4:0] addr;
        logic [3:0] data;
        logic       exp_valid;
        logic [3:0] exp_data;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one command on instance A, apply it to the model and check the result.
    task automatic run_cmd(input logic [1:0] op, input logic [4:0] addr,
                           input logic [3:0] data, input logic [4:0] len);
        int exp_lat;
        int waited;
        check("cmd_ready_before_accept", CMD_READY, 1);
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_ADDR  = addr;
        CMD_DATA  = data;
        CMD_LEN   = len;
        tick();
        CMD_VALID = 1'b0;
        CMD_ADDR  = 5'($urandom);
        CMD_DATA  = 4'($urandom);
        CMD_LEN   = 5'($urandom);
        case (op)
            2'b00: begin
                last_rd = ref_mem[addr];
                check("read_valid", RD_VALID, 1);
                check("read_data", RD_DATA, last_rd);
                check("read_perr", RD_PERR, 0);
            end
            2'b01: begin
                ref_mem[addr] = data;
                check("write_no_rd_valid", RD_VALID, 0);
                check("rd_data_hold", RD_DATA, last_rd);
            end
            default: begin
                exp_lat = (op == 2'b10) ? int'(len) : 31;
                waited  = 0;
                while (DONE !== 1'b1 && waited < 40) begin
                    check("busy_during_seq", BUSY, 1);
                    check("ready_low_during_seq", CMD_READY, 0);
                    tick();
                    waited++;
                end
                check("done_latency", waited, exp_lat);
                check("busy_low_at_done", BUSY, 0);
                check("ready_at_done", CMD_READY, 1);
                if (op == 2'b10) begin
                    for (int k = 0; k <= int'(len); k++) ref_mem[(int'(addr) + k) % 32] = data;
                end else begin
                    for (int k = 0; k < 32; k++) ref_mem[k] = 4'h0;
                end
            end
        endcase
    endtask

    task automatic b_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] data);
        check("b_ready", b_cmd_ready, 1);
        b_cmd_valid = 1'b1;
        b_cmd_op    = op;
        b_cmd_addr  = addr;
        b_cmd_data  = data;
        b_cmd_len   = 4'h0;
        tick();
        b_cmd_valid = 1'b0;
    endtask

    initial begin
        int r;
        RST = 1'b1; CMD_VALID = 1'b1; CMD_OP = 2'b01; CMD_ADDR = 5'd0; CMD_DATA = 4'h5; CMD_LEN = 5'd0;
        b_rst = 1'b1; b_cmd_valid = 1'b0; b_cmd_op = 2'b00; b_cmd_addr = 4'h0; b_cmd_data = 8'h00; b_cmd_len = 4'h0;
        last_rd = 4'h0;
        for (int k = 0; k < 32; k++) ref_mem[k] = 4'h0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("reset_ready_low", CMD_READY, 0);
        check("reset_busy", BUSY, 0);
        check("reset_done", DONE, 0);
        check("reset_rd_valid", RD_VALID, 0);
        check("reset_rd_data", RD_DATA, 0);
        check("reset_rd_perr", RD_PERR, 0);
        RST = 1'b0; CMD_VALID = 1'b0; b_rst = 1'b0;
        #1;
        check("ready_after_reset", CMD_READY, 1);

        // ---------------- table-driven back-to-back read/write ----------------
        vecs[0] = '{2'b01, 5'd3,  4'hA, 1'b0, 4'h0};
        vecs[1] = '{2'b00, 5'd3,  4'h0, 1'b1, 4'hA};
        vecs[2] = '{2'b01, 5'd0,  4'hF, 1'b0, 4'hA};
        vecs[3] = '{2'b01, 5'd31, 4'h1, 1'b0, 4'hA};
        vecs[4] = '{2'b00, 5'd0,  4'h0, 1'b1, 4'hF};
        vecs[5] = '{2'b00, 5'd31, 4'h0, 1'b1, 4'h1};
        vecs[6] = '{2'b01, 5'd3,  4'h6, 1'b0, 4'h1};
        vecs[7] = '{2'b00, 5'd3,  4'h0, 1'b1, 4'h6};
        vecs[8] = '{2'b01, 5'd16, 4'h0, 1'b0, 4'h6};
        vecs[9] = '{2'b00, 5'd16, 4'h0, 1'b1, 4'h0};
        for (int i = 0; i < 10; i++) begin
            check("tbl_ready", CMD_READY, 1);
            CMD_VALID = 1'b1; CMD_OP = vecs[i].op; CMD_ADDR = vecs[i].addr;
            CMD_DATA = vecs[i].data; CMD_LEN = 5'd0;
            tick();
            if (vecs[i].op == 2'b01) ref_mem[vecs[i].addr] = vecs[i].data;
            check("tbl_rd_valid", RD_VALID, vecs[i].exp_valid);
            check("tbl_rd_data", RD_DATA, vecs[i].exp_data);
            check("tbl_rd_perr", RD_PERR, 0);
        end
        CMD_VALID = 1'b0;
        last_rd = 4'h0;
        tick();
        check("rd_valid_one_cycle", RD_VALID, 0);
        check("rd_data_held", RD_DATA, 4'h0);

        // ---------------- fill with wrap: addr 30, len 3, data 5 ----------------
        run_cmd(2'b01, 5'd2, 4'h9, 5'd0);
        run_cmd(2'b01, 5'd30, 4'h0, 5'd0);
        run_cmd(2'b01, 5'd31, 4'h0, 5'd0);
        run_cmd(2'b01, 5'd0, 4'h0, 5'd0);
        run_cmd(2'b01, 5'd1, 4'h0, 5'd0);
        run_cmd(2'b10, 5'd30, 4'h5, 5'd3);
        tick();
        check("done_one_cycle", DONE, 0);
        run_cmd(2'b00, 5'd30, 4'h0, 5'd0);
        check("fill_addr30", RD_DATA, 4'h5);
        run_cmd(2'b00, 5'd31, 4'h0, 5'd0);
        run_cmd(2'b00, 5'd0, 4'h0, 5'd0);
        run_cmd(2'b00, 5'd1, 4'h0, 5'd0);
        check("fill_addr1", RD_DATA, 4'h5);
        run_cmd(2'b00, 5'd2, 4'h0, 5'd0);
        check("fill_addr2_unchanged", RD_DATA, 4'h9);
        // single-word fill: DONE at the cycle right after accept
        run_cmd(2'b10, 5'd12, 4'h3, 5'd0);
        // full-depth fill wraps and writes every word once
        run_cmd(2'b10, 5'd7, 4'hB, 5'd31);
        run_cmd(2'b00, 5'd6, 4'h0, 5'd0);
        check("full_fill_addr6", RD_DATA, 4'hB);

        // ---------------- clear after random writes ----------------
        for (int i = 0; i < 8; i++) run_cmd(2'b01, 5'($urandom), 4'($urandom_range(1, 15)), 5'd0);
        run_cmd(2'b11, 5'($urandom), 4'($urandom), 5'($urandom));
        for (int a = 0; a < 32; a++) begin
            run_cmd(2'b00, 5'(a), 4'h0, 5'd0);
            check("clear_zero", RD_DATA, 4'h0);
        end

        // ---------------- reset aborts a fill ----------------
        for (int a = 10; a < 16; a++) run_cmd(2'b01, 5'(a), 4'(a - 9), 5'd0);
        check("abort_ready", CMD_READY, 1);
        CMD_VALID = 1'b1; CMD_OP = 2'b10; CMD_ADDR = 5'd10; CMD_DATA = 4'hC; CMD_LEN = 5'd5;
        tick();                       // writes word 10
        CMD_VALID = 1'b0;
        check("abort_busy", BUSY, 1);
        tick();                       // writes word 11
        RST = 1'b1;
        tick();                       // aborted, nothing written
        RST = 1'b0;
        #1;
        check("abort_busy_low", BUSY, 0);
        check("abort_no_done", DONE, 0);
        check("abort_ready_after", CMD_READY, 1);
        ref_mem[10] = 4'hC;
        ref_mem[11] = 4'hC;
        last_rd = 4'h0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_late_done", DONE, 0);
        end
        for (int a = 10; a < 16; a++) run_cmd(2'b00, 5'(a), 4'h0, 5'd0);
        run_cmd(2'b00, 5'd12, 4'h0, 5'd0);
        check("abort_addr12_kept", RD_DATA, 4'h3);

        // ---------------- randomized commands vs model ----------------
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            if (r < 8)       run_cmd(2'b00, 5'($urandom), 4'h0, 5'd0);
            else if (r < 16) run_cmd(2'b01, 5'($urandom), 4'($urandom), 5'd0);
            else if (r < 19) run_cmd(2'b10, 5'($urandom), 4'($urandom), 5'($urandom));
            else             run_cmd(2'b11, 5'($urandom), 4'($urandom), 5'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                tick();
                check("idle_rd_valid", RD_VALID, 0);
                check("idle_rd_data_hold", RD_DATA, last_rd);
                check("idle_done", DONE, 0);
            end
        end

        // ---------------- instance B: write then read, no stall ----------------
        b_cmd(2'b01, 4'd5, 8'h3C);
        b_cmd(2'b00, 4'd5, 8'h00);
        check("b_rd_valid", b_rd_valid, 1);
        check("b_rd_data", b_rd_data, 8'h3C);
        b_cmd(2'b01, 4'd5, 8'hA5);
        b_cmd(2'b00, 4'd5, 8'h00);
        check("b_rd_data_2", b_rd_data, 8'hA5);
        b_cmd(2'b01, 4'd15, 8'h5A);
        b_cmd(2'b00, 4'd15, 8'h00);
        check("b_rd_data_3", b_rd_data, 8'h5A);
        check("b_rd_perr", b_rd_perr, 0);
        check("b_busy", b_busy, 0);
        check("b_done", b_done, 0);
        tick();
        check("b_rd_valid_drop", b_rd_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
